sort1_seq_ctrl: RTL and testbench

Sequencer for the sort1 datapath. Owns a DEPTH-entry element buffer loaded through a simple indexed write port, which the sort1 AXI4-Lite register block drives. On a start command it runs an in-place bubble sort with one compare/swap per clock and early exit. Reports busy/done status and, optionally, comparison and swap statistics back to the register block.

---
 rtl/sort1_seq_ctrl_if.sv | 27 ++
 rtl/sort1_seq_ctrl.sv | 112 +++++++++++
 tb/tb_sort1_seq_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sort1_seq_ctrl_if.sv
// sort1_seq_ctrl_if: element write/read port, sort command and status bundle for sort1_seq_ctrl
interface sort1_seq_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int IDX_W = $clog2(DEPTH);
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  start;
    logic                  descending;
    logic                  busy;
    logic                  done;
    logic                  wr_err;
    logic [15:0]           cmp_cnt;
    logic [15:0]           swap_cnt;
    modport master (
        output wr_en, wr_idx, wr_data, rd_idx, start, descending,
        input  rd_data, busy, done, wr_err, cmp_cnt, swap_cnt
    );
    modport slave (
        input  wr_en, wr_idx, wr_data, rd_idx, start, descending,
        output rd_data, busy, done, wr_err, cmp_cnt, swap_cnt
    );
endinterface

// File: rtl/sort1_seq_ctrl.sv
// sort1_seq_ctrl: in-place bubble sort sequencer, one compare/swap per clock; define SORT1_SEQ_STATS_EN to build compare/swap counters
module sort1_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic ACLK,
    input logic ARESETN,
    sort1_seq_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, a, b;
    logic [IDX_W-1:0]      j_q, j_d, last_q, last_d;
    logic                  desc_q, desc_d, swapped_q, swapped_d, wr_err_q, wr_err_d, ooo;
    // state, buffer and pass bookkeeping registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_data_q <= '0;
            j_q       <= '0;
            last_q    <= '0;
            desc_q    <= 1'b0;
            swapped_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
            j_q       <= j_d;
            last_q    <= last_d;
            desc_q    <= desc_d;
            swapped_q <= swapped_d;
            wr_err_q  <= wr_err_d;
        end
    end
    // next state: writes in IDLE, one compare/swap per RUN cycle, early exit on a swap-free pass
    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        j_d       = j_q;
        last_d    = last_q;
        desc_d    = desc_q;
        swapped_d = swapped_q;
        a         = '0;
        b         = '0;
        rd_data_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (IDX_W'(i) == j_q) a = mem_q[i];
            if (IDX_W'(i) == j_q + IDX_W'(1)) b = mem_q[i];
            if (IDX_W'(i) == bus.rd_idx) rd_data_d = mem_q[i];
        end
        ooo      = desc_q ? (a < b) : (a > b);
        wr_err_d = bus.wr_en && state_q != IDLE;
        case (state_q)
            IDLE: begin
                for (int i = 0; i < DEPTH; i++)
                    if (bus.wr_en && IDX_W'(i) == bus.wr_idx) mem_d[i] = bus.wr_data;
                if (bus.start) begin
                    state_d   = RUN;
                    desc_d    = bus.descending;
                    j_d       = '0;
                    last_d    = IDX_W'(DEPTH - 1);
                    swapped_d = 1'b0;
                end
            end
            RUN: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ooo && IDX_W'(i) == j_q) mem_d[i] = b;
                    if (ooo && IDX_W'(i) == j_q + IDX_W'(1)) mem_d[i] = a;
                end
                swapped_d = swapped_q | ooo;
                if (j_q < last_q - IDX_W'(1)) j_d = j_q + IDX_W'(1);
                else if (!(swapped_q | ooo) || last_q == IDX_W'(1)) state_d = DONE;
                else begin
                    last_d    = last_q - IDX_W'(1);
                    j_d       = '0;
                    swapped_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`ifdef SORT1_SEQ_STATS_EN
    logic [15:0] cmp_q, swp_q;
    // saturating compare/swap counters, cleared when a sort is accepted
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cmp_q <= '0;
            swp_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            cmp_q <= '0;
            swp_q <= '0;
        end else if (state_q == RUN) begin
            cmp_q <= cmp_q + 16'(cmp_q != 16'hFFFF);
            swp_q <= swp_q + 16'(ooo && swp_q != 16'hFFFF);
        end
    end
    assign bus.cmp_cnt  = cmp_q;
    assign bus.swap_cnt = swp_q;
`else
    assign bus.cmp_cnt  = '0;
    assign bus.swap_cnt = '0;
`endif
    assign bus.rd_data = rd_data_q;
    assign bus.busy    = state_q != IDLE;
    assign bus.done    = state_q == DONE;
    assign bus.wr_err  = wr_err_q;
endmodule

// File: tb/tb_sort1_seq_ctrl.sv
// tb_sort1_seq_ctrl: directed and randomized checks of sort1_seq_ctrl against a behavioural sort model
module tb_sort1_seq_ctrl;
    localparam int DW = 32;
    localparam int DEPTH = 4;
`ifdef SORT1_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    typedef logic [DW-1:0] arr_t [DEPTH];
    localparam arr_t DOWN = '{32'd4, 32'd3, 32'd2, 32'd1};
    localparam arr_t UP   = '{32'd1, 32'd2, 32'd3, 32'd4};
    localparam arr_t SAME = '{32'd5, 32'd5, 32'd5, 32'd5};
    localparam arr_t MIX  = '{32'd2, 32'd1, 32'd4, 32'd3};
    localparam arr_t ZERO = '{32'd0, 32'd0, 32'd0, 32'd0};

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    int checks = 0;
    int errors = 0;
    int werr_pulses = 0;

    sort1_seq_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
    sort1_seq_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (.ACLK(ACLK), .ARESETN(ARESETN), .bus(bus));

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference sort: repeated passes over a shrinking prefix, stopping after a swap-free pass
    function automatic void msort(input arr_t a, input bit d, output arr_t r, output int c, output int s);
        logic [DW-1:0] t;
        bit sw;
        r = a;
        c = 0;
        s = 0;
        for (int last = DEPTH - 1; last >= 1; last--) begin
            sw = 1'b0;
            for (int j = 0; j < last; j++) begin
                c++;
                if (d ? r[j] < r[j+1] : r[j] > r[j+1]) begin
                    t = r[j]; r[j] = r[j+1]; r[j+1] = t;
                    s++;
                    sw = 1'b1;
                end
            end
            if (!sw) break;
        end
    endfunction

    // per-cycle model: remaining busy cycles, buffer contents as seen when not mid-sort, last counts
    arr_t mbuf;
    int rem = 0, mc = 0, ms = 0;
    logic e_busy, e_done, e_err, e_rd_chk, e_cnt_chk;
    logic [DW-1:0] e_rd;
    bit have = 1'b0;
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            chk("rst_busy", 64'(bus.busy), 64'(0));
            chk("rst_done", 64'(bus.done), 64'(0));
            chk("rst_wr_err", 64'(bus.wr_err), 64'(0));
            chk("rst_rd_data", 64'(bus.rd_data), 64'(0));
            chk("rst_cmp_cnt", 64'(bus.cmp_cnt), 64'(0));
            chk("rst_swap_cnt", 64'(bus.swap_cnt), 64'(0));
            foreach (mbuf[i]) mbuf[i] = '0;
            rem = 0; mc = 0; ms = 0;
            e_busy = 0; e_done = 0; e_err = 0; e_rd = '0; e_rd_chk = 1; e_cnt_chk = 1;
            have = 1'b1;
        end else begin
            if (have) begin
                chk("busy", 64'(bus.busy), 64'(e_busy));
                chk("done", 64'(bus.done), 64'(e_done));
                chk("wr_err", 64'(bus.wr_err), 64'(e_err));
                if (e_rd_chk) chk("rd_data", 64'(bus.rd_data), 64'(e_rd));
                if (e_cnt_chk) begin
                    chk("cmp_cnt", 64'(bus.cmp_cnt), 64'(STATS ? mc : 0));
                    chk("swap_cnt", 64'(bus.swap_cnt), 64'(STATS ? ms : 0));
                end
            end
            if (bus.wr_err) werr_pulses++;
            e_err = bus.wr_en && rem > 0;
            e_rd_chk = rem <= 1;
            e_rd = mbuf[bus.rd_idx];
            if (rem > 0) rem--;
            else begin
                if (bus.wr_en) mbuf[bus.wr_idx] = bus.wr_data;
                if (bus.start) begin
                    msort(mbuf, bus.descending, mbuf, mc, ms);
                    rem = mc + 1;
                end
            end
            e_busy = rem > 0;
            e_done = rem == 1;
            e_cnt_chk = rem <= 1;
            have = 1'b1;
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic pin(input string name, input arr_t a, input bit d, input arr_t er, input int ec, input int es);
        arr_t r;
        int c, s;
        msort(a, d, r, c, s);
        for (int i = 0; i < DEPTH; i++) chk(name, 64'(r[i]), 64'(er[i]));
        chk(name, 64'(c), 64'(ec));
        chk(name, 64'(s), 64'(es));
    endtask

    task automatic load(input arr_t v);
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_idx = 2'(i);
            bus.wr_data = v[i];
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 200) begin
            n++;
            tick();
        end
        chk(name, 64'(bus.busy), 64'(0));
    endtask

    task automatic sort_run(input bit d, input int exp_busy, input int ec, input int es);
        int n = 0, dp = 0;
        bus.start = 1'b1;
        bus.descending = d;
        tick();
        bus.start = 1'b0;
        while (bus.busy && n < 200) begin
            n++;
            if (bus.done) dp = n;
            tick();
        end
        chk("busy_cycles", 64'(n), 64'(exp_busy));
        chk("done_cycle", 64'(dp), 64'(exp_busy));
        chk("final_cmp", 64'(bus.cmp_cnt), 64'(STATS ? ec : 0));
        chk("final_swap", 64'(bus.swap_cnt), 64'(STATS ? es : 0));
    endtask

    task automatic chk_buf(input string name, input arr_t e);
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_idx = 2'(i);
            tick();
            tick();
            chk(name, 64'(bus.rd_data), 64'(e[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.wr_en = 0; bus.wr_idx = '0; bus.wr_data = '0;
        bus.rd_idx = '0; bus.start = 0; bus.descending = 0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        tick();
        pin("pin_down_asc", DOWN, 1'b0, UP, 6, 6);
        pin("pin_up_asc", UP, 1'b0, UP, 3, 0);
        pin("pin_up_desc", UP, 1'b1, DOWN, 6, 6);
        pin("pin_same", SAME, 1'b0, SAME, 3, 0);
        pin("pin_mix", MIX, 1'b0, UP, 5, 2);

        load(DOWN); sort_run(1'b0, 7, 6, 6); chk_buf("buf_down_asc", UP);
        load(UP);   sort_run(1'b0, 4, 3, 0); chk_buf("buf_up_asc", UP);
        load(UP);   sort_run(1'b1, 7, 6, 6); chk_buf("buf_up_desc", DOWN);
        load(SAME); sort_run(1'b0, 4, 3, 0); chk_buf("buf_same", SAME);

        werr_pulses = 0;
        load(DOWN);
        bus.start = 1'b1; bus.descending = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        bus.wr_en = 1'b1; bus.wr_idx = 2'd0; bus.wr_data = 32'd9;
        tick();
        bus.wr_en = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_idle("werr_idle");
        chk("wr_err_pulses", 64'(werr_pulses), 64'(1));
        chk("werr_cmp", 64'(bus.cmp_cnt), 64'(STATS ? 6 : 0));
        chk_buf("buf_werr", UP);

        load(DOWN);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        ARESETN = 1'b0;
        #1;
        chk("async_busy", 64'(bus.busy), 64'(0));
        chk("async_done", 64'(bus.done), 64'(0));
        chk("async_cmp", 64'(bus.cmp_cnt), 64'(0));
        chk("async_swap", 64'(bus.swap_cnt), 64'(0));
        tick();
        ARESETN = 1'b1;
        tick();
        chk_buf("buf_after_rst", ZERO);
        load(MIX); sort_run(1'b0, 6, 5, 2); chk_buf("buf_mix", UP);

        repeat (800) begin
            bus.wr_en = $urandom_range(0, 3) == 0;
            bus.wr_idx = 2'($urandom);
            bus.wr_data = $urandom_range(0, 1) == 0 ? $urandom : 32'($urandom_range(0, 7));
            bus.rd_idx = 2'($urandom);
            bus.start = $urandom_range(0, 4) == 0;
            bus.descending = 1'($urandom);
            tick();
        end
        bus.wr_en = 0;
        bus.start = 0;
        wait_idle("rand_idle");
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
